// File: rtl/priority_disp_pkg.sv
// Shared constants for the priority decode/display slice: seven-segment glyphs,
// BCD counter geometry and history depth.
package priority_disp_pkg;

    localparam int BCD_W      = 4;
    localparam int BCD_DIGITS = 4;
    localparam int HIST_DEPTH = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;
    typedef logic [2:0]       code_t;

    // Segment order is {a,b,c,d,e,f,g,dp}, bit7 = a, active-high.
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] DP_MASK   = 8'h01;

endpackage

// File: rtl/seg7_digit_encode.sv
// Combinational glyph lookup for one seven-segment digit; blank wins over
// both the glyph and the decimal point.
module seg7_digit_encode
    import priority_disp_pkg::*;
(
    input  logic [BCD_W-1:0] value,
    input  logic             blank,
    input  logic             dp,
    output logic [7:0]       seg
);

    logic [7:0] glyph;

    always_comb begin
        case (value)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = glyph | (dp ? DP_MASK : SEG_BLANK);
        end
    end

endmodule

// File: rtl/priority_decode_display.sv
// Receive end of the priority-encoder path: decodes accepted codes to a one-hot
// LED pattern and scans code history (right bank) and a BCD accept count (left bank).
module priority_decode_display
    import priority_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       n_EN,
    input  logic [2:0] code_in,
    input  logic       code_valid,
    output logic [7:0] dec_led,
    output logic [7:0] a_to_g_left,
    output logic [7:0] a_to_g_right,
    output logic [3:0] leftseg,
    output logic [3:0] rightseg
);

    localparam logic [19:0] PRE_LAST = 20'(SCAN_DIV - 1);

    code_t                 held_code;
    logic                  hold_valid;
    code_t                 hist       [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hist_valid;
    bcd_digit_t            bcd        [BCD_DIGITS];
    bcd_digit_t            bcd_next   [BCD_DIGITS];
    logic                  bcd_carry;
    logic [19:0]           prescaler;
    logic [1:0]            scan_idx;
    logic                  accept;

    bcd_digit_t            right_value;
    logic                  right_blank;
    logic                  right_dp;
    logic [7:0]            right_seg;
    logic [7:0]            left_seg;

    assign accept = code_valid && !n_EN;

    // Ripple-carry decimal increment; 9999 rolls over to 0000 naturally.
    always_comb begin
        bcd_carry = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            bcd_next[i] = bcd[i];
            if (bcd_carry) begin
                if (bcd[i] == 4'd9) begin
                    bcd_next[i] = '0;
                end else begin
                    bcd_next[i] = bcd[i] + 4'd1;
                    bcd_carry   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_code  <= '0;
            hold_valid <= 1'b0;
            hist_valid <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
            for (int i = 0; i < BCD_DIGITS; i++) bcd[i] <= '0;
        end else if (accept) begin
            held_code  <= code_in;
            hold_valid <= 1'b1;
            hist[0]    <= code_in;
            for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
            hist_valid <= {hist_valid[HIST_DEPTH-2:0], 1'b1};
            for (int i = 0; i < BCD_DIGITS; i++) bcd[i] <= bcd_next[i];
        end
    end

    // Scan keeps running while disabled so re-enable resumes mid-cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            scan_idx  <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            scan_idx  <= scan_idx + 2'd1;
        end else begin
            prescaler <= prescaler + 20'd1;
        end
    end

    assign right_value = {1'b0, hist[scan_idx]};
    assign right_blank = !hist_valid[scan_idx];
    assign right_dp    = (scan_idx == 2'd0);

    seg7_digit_encode u_right_enc (
        .value (right_value),
        .blank (right_blank),
        .dp    (right_dp),
        .seg   (right_seg)
    );

    seg7_digit_encode u_left_enc (
        .value (bcd[scan_idx]),
        .blank (1'b0),
        .dp    (1'b0),
        .seg   (left_seg)
    );

    always_ff @(posedge clk) begin
        if (rst || n_EN) begin
            dec_led      <= '0;
            a_to_g_left  <= '0;
            a_to_g_right <= '0;
            leftseg      <= '0;
            rightseg     <= '0;
        end else begin
            dec_led      <= hold_valid ? (8'd1 << held_code) : 8'd0;
            a_to_g_left  <= left_seg;
            a_to_g_right <= right_seg;
            leftseg      <= 4'd1 << scan_idx;
            rightseg     <= 4'd1 << scan_idx;
        end
    end

endmodule

// File: tb/tb_priority_decode_display.sv
// Self-checking bench for priority_decode_display with a queue-based reference
// model of history, decimal count and scan position.
module tb_priority_decode_display;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       n_EN;
    logic [2:0] code_in;
    logic       code_valid;
    logic [7:0] dec_led;
    logic [7:0] a_to_g_left;
    logic [7:0] a_to_g_right;
    logic [3:0] leftseg;
    logic [3:0] rightseg;

    always #5 clk = ~clk;

    priority_decode_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .n_EN         (n_EN),
        .code_in      (code_in),
        .code_valid   (code_valid),
        .dec_led      (dec_led),
        .a_to_g_left  (a_to_g_left),
        .a_to_g_right (a_to_g_right),
        .leftseg      (leftseg),
        .rightseg     (rightseg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    int         hist_q [$];
    int         model_count;
    int         model_held;
    bit         model_hv;
    int         ticks;
    logic [7:0] exp_dec, exp_left, exp_right;
    logic [3:0] exp_lsel, exp_rsel;

    // Expected outputs reflect the model state as it stood before each edge.
    always @(posedge clk) begin
        int idx;
        if (rst) begin
            {exp_dec, exp_left, exp_right, exp_lsel, exp_rsel} = '0;
            hist_q.delete();
            model_count = 0;
            model_held  = 0;
            model_hv    = 0;
            ticks       = 0;
        end else begin
            idx = (ticks / SCAN_DIV) % 4;
            if (n_EN) begin
                {exp_dec, exp_left, exp_right, exp_lsel, exp_rsel} = '0;
            end else begin
                exp_dec   = model_hv ? 8'(1 << model_held) : 8'h00;
                exp_rsel  = 4'(1 << idx);
                exp_lsel  = exp_rsel;
                exp_left  = seg_tab[(model_count / (10 ** idx)) % 10];
                exp_right = (idx < hist_q.size())
                          ? (seg_tab[hist_q[idx]] | ((idx == 0) ? 8'h01 : 8'h00)) : 8'h00;
            end
            ticks++;
            if (code_valid && !n_EN) begin
                model_held = int'(code_in);
                model_hv   = 1;
                hist_q.push_front(int'(code_in));
                if (hist_q.size() > 4) void'(hist_q.pop_back());
                model_count = (model_count + 1) % 10000;
            end
        end
    end

    function automatic logic [31:0] dut_vec();
        return {dec_led, a_to_g_left, a_to_g_right, leftseg, rightseg};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {exp_dec, exp_left, exp_right, exp_lsel, exp_rsel};
    endfunction

    logic [7:0]  r_seen [4];
    logic [7:0]  l_seen [4];
    logic [3:0]  first_rs;
    int          model_diffs;
    logic [31:0] bad_dut, bad_exp;

    // Observes one scan window, recording each digit's segments and any model divergence.
    task automatic scan_window(input int n);
        model_diffs = 0;
        first_rs    = 'x;
        for (int d = 0; d < 4; d++) begin
            r_seen[d] = 'x;
            l_seen[d] = 'x;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) first_rs = rightseg;
            if (dut_vec() !== exp_vec()) begin
                if (model_diffs == 0) begin
                    bad_dut = dut_vec();
                    bad_exp = exp_vec();
                end
                model_diffs++;
            end
            for (int d = 0; d < 4; d++) begin
                if (rightseg === 4'(1 << d)) begin
                    r_seen[d] = a_to_g_right;
                    l_seen[d] = a_to_g_left;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; n_EN = 1'b0; code_valid = 1'b0; code_in = 3'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec() !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", dut_vec(), 32'h0);
        end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (rightseg !== 4'(1 << ((k / 4) % 4)) || a_to_g_right !== 8'h00 ||
                a_to_g_left !== 8'hFC || dec_led !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL reset_walk cycle %0d: got %h expected sel %h right 00 left FC led 00",
                         k, dut_vec(), 4'(1 << ((k / 4) % 4)));
            end
        end
        scan_window(16);
        n_checks++;
        if (model_diffs !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_model: %0d cycles differ, first got %h expected %h",
                     model_diffs, bad_dut, bad_exp);
        end
    endtask

    task automatic test_single_strobe();
        code_valid = 1'b1; code_in = 3'd5;
        @(negedge clk);
        code_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dec_led !== 8'h20) begin
            n_fail++;
            $display("[TB] FAIL single_dec_led: got %h expected %h", dec_led, 8'h20);
        end
        scan_window(16);
        n_checks++;
        if ({r_seen[3], r_seen[2], r_seen[1], r_seen[0]} !== 32'h000000B7) begin
            n_fail++;
            $display("[TB] FAIL single_right: got %h expected %h",
                     {r_seen[3], r_seen[2], r_seen[1], r_seen[0]}, 32'h000000B7);
        end
        n_checks++;
        if ({l_seen[3], l_seen[2], l_seen[1], l_seen[0]} !== 32'hFCFCFC60) begin
            n_fail++;
            $display("[TB] FAIL single_left: got %h expected %h",
                     {l_seen[3], l_seen[2], l_seen[1], l_seen[0]}, 32'hFCFCFC60);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] burst [4] = '{3'd3, 3'd7, 3'd0, 3'd6};
        for (int i = 0; i < 4; i++) begin
            code_valid = 1'b1; code_in = burst[i];
            @(negedge clk);
        end
        code_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dec_led !== 8'h40) begin
            n_fail++;
            $display("[TB] FAIL burst_dec_led: got %h expected %h", dec_led, 8'h40);
        end
        scan_window(16);
        n_checks++;
        if ({r_seen[3], r_seen[2], r_seen[1], r_seen[0]} !== 32'hF2E0FCBF) begin
            n_fail++;
            $display("[TB] FAIL burst_right: got %h expected %h",
                     {r_seen[3], r_seen[2], r_seen[1], r_seen[0]}, 32'hF2E0FCBF);
        end
        n_checks++;
        if ({l_seen[3], l_seen[2], l_seen[1], l_seen[0]} !== 32'hFCFCFCB6) begin
            n_fail++;
            $display("[TB] FAIL burst_left: got %h expected %h",
                     {l_seen[3], l_seen[2], l_seen[1], l_seen[0]}, 32'hFCFCFCB6);
        end
        n_checks++;
        if (model_diffs !== 0) begin
            n_fail++;
            $display("[TB] FAIL burst_model: %0d cycles differ, first got %h expected %h",
                     model_diffs, bad_dut, bad_exp);
        end
    endtask

    task automatic test_disable();
        n_EN = 1'b1; code_valid = 1'b1; code_in = 3'd2;
        @(negedge clk);
        code_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (dut_vec() !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL disable_outputs cycle %0d: got %h expected %h", k, dut_vec(), 32'h0);
            end
            @(negedge clk);
        end
        n_EN = 1'b0;
        @(negedge clk);
        scan_window(16);
        n_checks++;
        if ({r_seen[3], r_seen[2], r_seen[1], r_seen[0]} !== 32'hF2E0FCBF) begin
            n_fail++;
            $display("[TB] FAIL reenable_right: got %h expected %h",
                     {r_seen[3], r_seen[2], r_seen[1], r_seen[0]}, 32'hF2E0FCBF);
        end
        n_checks++;
        if ({l_seen[3], l_seen[2], l_seen[1], l_seen[0]} !== 32'hFCFCFCB6) begin
            n_fail++;
            $display("[TB] FAIL reenable_left: got %h expected %h",
                     {l_seen[3], l_seen[2], l_seen[1], l_seen[0]}, 32'hFCFCFCB6);
        end
        n_checks++;
        if (dec_led !== 8'h40 || model_diffs !== 0) begin
            n_fail++;
            $display("[TB] FAIL reenable_state: led %h expected %h, %0d model diffs",
                     dec_led, 8'h40, model_diffs);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            code_valid = ($urandom_range(0, 1) == 1);
            code_in    = 3'($urandom_range(0, 7));
            n_EN       = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
        code_valid = 1'b0; n_EN = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bcd_wrap();
        int target;
        target = 9999 - model_count;
        for (int k = 0; k < target; k++) begin
            code_valid = 1'b1;
            code_in    = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        code_valid = 1'b0;
        @(negedge clk);
        scan_window(16);
        n_checks++;
        if ({l_seen[3], l_seen[2], l_seen[1], l_seen[0]} !== 32'hF6F6F6F6 || model_diffs !== 0) begin
            n_fail++;
            $display("[TB] FAIL count_9999: got %h expected %h, %0d model diffs",
                     {l_seen[3], l_seen[2], l_seen[1], l_seen[0]}, 32'hF6F6F6F6, model_diffs);
        end
        code_valid = 1'b1; code_in = 3'd1;
        @(negedge clk);
        code_valid = 1'b0;
        @(negedge clk);
        scan_window(16);
        n_checks++;
        if ({l_seen[3], l_seen[2], l_seen[1], l_seen[0]} !== 32'hFCFCFCFC || model_diffs !== 0) begin
            n_fail++;
            $display("[TB] FAIL count_wrap: got %h expected %h, %0d model diffs",
                     {l_seen[3], l_seen[2], l_seen[1], l_seen[0]}, 32'hFCFCFCFC, model_diffs);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (rightseg === 4'b0100) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL midscan_wait: got rightseg %b expected %b within 64 cycles", rightseg, 4'b0100);
        end
        rst = 1'b1; code_valid = 1'b1; code_in = 3'd4;
        @(negedge clk);
        rst = 1'b0; code_valid = 1'b0;
        n_checks++;
        if (dut_vec() !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL midscan_outputs: got %h expected %h", dut_vec(), 32'h0);
        end
        scan_window(16);
        n_checks++;
        if (first_rs !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL midscan_restart: got %b expected %b", first_rs, 4'b0001);
        end
        n_checks++;
        if ({r_seen[3], r_seen[2], r_seen[1], r_seen[0]} !== 32'h0 ||
            {l_seen[3], l_seen[2], l_seen[1], l_seen[0]} !== 32'hFCFCFCFC || dec_led !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL midscan_cleared: right %h left %h led %h expected 00000000 FCFCFCFC 00",
                     {r_seen[3], r_seen[2], r_seen[1], r_seen[0]},
                     {l_seen[3], l_seen[2], l_seen[1], l_seen[0]}, dec_led);
        end
        n_checks++;
        if (model_diffs !== 0) begin
            n_fail++;
            $display("[TB] FAIL midscan_model: %0d cycles differ, first got %h expected %h",
                     model_diffs, bad_dut, bad_exp);
        end
    endtask

    initial begin
        test_reset();
        test_single_strobe();
        test_back_to_back();
        test_disable();
        test_random();
        test_bcd_wrap();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: got no completion expected finish before 1000000");
        $fatal(1, "[TB] timeout");
    end

endmodule
